maze_store: RTL and testbench

//  Maze storage for the wall-follower solver; sits directly below it.

---
 rtl/maze_pkg.sv | 15 +
 rtl/maze_loader.sv | 35 +++
 rtl/maze_store.sv | 131 +++++++++++++
 tb/tb_maze_store.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants and state encoding for the maze storage block.
package maze_pkg;

  localparam int MAZE_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam logic WALL = 1'b1;
  localparam logic FREE = 1'b0;

endpackage

// File: rtl/maze_loader.sv
// Raster counter and load handshake for streaming the wall map.
// Emits the write strobe, write address and last-cell flag.
module maze_loader
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    restart,
  input  logic                    active,
  input  logic                    load_valid,
  output logic                    wr_en,
  output logic [2*maze_width-1:0] wr_addr,
  output logic                    last
);

  logic [2*maze_width-1:0] cnt;

  assign wr_en   = active && load_valid;
  assign wr_addr = cnt;
  assign last    = wr_en && (&cnt);

  // Row is the upper half of the counter, so column wrap carries into row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (wr_en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/maze_store.sv
// Wall map and visited plane for the wall-follower solver.
// Define PATH_DUMP_EN to build the visited plane, dump port and visit_count.
module maze_store
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic                  load_data,
  output logic                  load_ready,
  output logic                  ready,
  input  logic [maze_width-1:0] row,
  input  logic [maze_width-1:0] col,
  input  logic                  maze_oe,
  input  logic                  maze_we,
  output logic                  maze_in
`ifdef PATH_DUMP_EN
  ,
  input  logic [maze_width-1:0] dump_row,
  input  logic [maze_width-1:0] dump_col,
  output logic                  dump_visited,
  output logic [2*maze_width:0] visit_count
`endif
);

  localparam int AW    = 2 * maze_width;
  localparam int DEPTH = 1 << AW;

  state_t          state;
  logic            restart;
  logic            wr_en;
  logic            last;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic            wall_mem [DEPTH];

  // load_start mid-load is ignored; otherwise it restarts the raster scan.
  assign restart = load_start && (state != ST_LOAD);
  assign rd_addr = {row, col};

  maze_loader #(
    .maze_width(maze_width)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .active    (load_ready),
    .load_valid(load_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      load_ready <= 1'b0;
      ready      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (load_start) begin
          state      <= ST_LOAD;
          load_ready <= 1'b1;
        end
        ST_LOAD: if (last) begin
          state      <= ST_READY;
          load_ready <= 1'b0;
          ready      <= 1'b1;
        end
        ST_READY: if (load_start) begin
          state      <= ST_LOAD;
          load_ready <= 1'b1;
          ready      <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          load_ready <= 1'b0;
          ready      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      wall_mem[wr_addr] <= load_data;
    end
  end

  // Before the map exists the solver sees walls everywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maze_in <= WALL;
    end else if (maze_oe) begin
      maze_in <= (state == ST_READY) ? wall_mem[rd_addr] : WALL;
    end
  end

`ifdef PATH_DUMP_EN
  logic [DEPTH-1:0] visited;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      visited     <= '0;
      visit_count <= '0;
    end else if (restart) begin
      visited     <= '0;
      visit_count <= '0;
    end else if (maze_we && state == ST_READY
                 && !visited[rd_addr]) begin
      visited[rd_addr] <= 1'b1;
      visit_count      <= visit_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_visited <= FREE;
    end else begin
      dump_visited <= visited[{dump_row, dump_col}];
    end
  end
`else
  logic unused_we;
  assign unused_we = maze_we ^ FREE;
`endif

endmodule

// File: tb/tb_maze_store.sv
// Scoreboard bench for maze_store: stimulus pushes expectations,
// a negedge monitor pops and compares them.
module tb_maze_store;

  localparam int S_READY = 0;
  localparam int S_LRDY  = 1;
  localparam int S_MIN   = 2;
  localparam int S_VCNT  = 3;
  localparam int S_LRCNT = 4;
  localparam int S_VAL   = 5;
  localparam int S_DRAIN = 6;
  localparam int S_DVIS  = 7;
  localparam int CELLS   = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_data = 1'b0;
  logic       load_ready;
  logic       ready;
  logic [5:0] row = '0;
  logic [5:0] col = '0;
  logic       maze_oe = 1'b0;
  logic       maze_we = 1'b0;
  logic       maze_in;
`ifdef PATH_DUMP_EN
  logic [5:0]  dump_row = '0;
  logic [5:0]  dump_col = '0;
  logic        dump_visited;
  logic [12:0] visit_count;
`endif

  int    checks = 0;
  int    errors = 0;
  int    lr_cnt = 0;
  int    lr_base = 0;
  bit    mdl [CELLS];
  bit    rd_q[$];
  bit    dp_q[$];
  string st_name[$];
  int    st_sig[$];
  int    st_act[$];
  int    st_exp[$];
  logic  oe_q = 1'b0;
  logic  dump_req = 1'b0;
  logic  dq_q = 1'b0;

  maze_store #(.maze_width(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .ready       (ready),
    .row         (row),
    .col         (col),
    .maze_oe     (maze_oe),
    .maze_we     (maze_we),
    .maze_in     (maze_in)
`ifdef PATH_DUMP_EN
    ,
    .dump_row    (dump_row),
    .dump_col    (dump_col),
    .dump_visited(dump_visited),
    .visit_count (visit_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    oe_q <= maze_oe;
    dq_q <= dump_req;
    if (load_ready === 1'b1) lr_cnt <= lr_cnt + 1;
  end

  function automatic void cmp(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic int sig_val(int sig, int act);
    int v;
    v = -1;
    case (sig)
      S_READY: v = int'(ready);
      S_LRDY:  v = int'(load_ready);
      S_MIN:   v = int'(maze_in);
      S_LRCNT: v = lr_cnt - lr_base;
      S_VAL:   v = act;
      S_DRAIN: v = rd_q.size() + dp_q.size();
`ifdef PATH_DUMP_EN
      S_VCNT:  v = int'(visit_count);
      S_DVIS:  v = int'(dump_visited);
`endif
      default: v = -1;
    endcase
    return v;
  endfunction

  // Monitor: read and dump responses first, then status items.
  always @(negedge clk) begin
    if (oe_q) begin
      if (rd_q.size() == 0) cmp("rd_unexpected", 1, 0);
      else cmp("maze_in", int'(maze_in), int'(rd_q.pop_front()));
    end
`ifdef PATH_DUMP_EN
    if (dq_q) begin
      if (dp_q.size() == 0) cmp("dump_unexpected", 1, 0);
      else cmp("dump_visited", int'(dump_visited), int'(dp_q.pop_front()));
    end
`endif
    while (st_sig.size() > 0) begin
      int s;
      int a;
      string n;
      s = st_sig.pop_front();
      a = st_act.pop_front();
      n = st_name.pop_front();
      cmp(n, sig_val(s, a), st_exp.pop_front());
    end
  end

  function automatic bit pat_a(int idx);
    return ((idx >> 6) == 0) || ((idx & 63) == 0);
  endfunction

  function automatic bit pat_b(int idx);
    return bit'(((idx * 37) ^ (idx >> 3)) & 1);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  task automatic expect_st(input string n, input int sig, input int exp,
                           input int act = 0);
    st_name.push_back(n);
    st_sig.push_back(sig);
    st_exp.push_back(exp);
    st_act.push_back(act);
  endtask

  task automatic rd(input int r, input int c, input bit e);
    row = 6'(r);
    col = 6'(c);
    maze_oe = 1'b1;
    rd_q.push_back(e);
    step;
    maze_oe = 1'b0;
  endtask

  task automatic mark(input int r, input int c);
    row = 6'(r);
    col = 6'(c);
    maze_we = 1'b1;
    step;
    maze_we = 1'b0;
  endtask

`ifdef PATH_DUMP_EN
  task automatic dmp(input int r, input int c, input bit e);
    dump_row = 6'(r);
    dump_col = 6'(c);
    dump_req = 1'b1;
    dp_q.push_back(e);
    step;
    dump_req = 1'b0;
  endtask
`endif

  task automatic start_load;
    load_start = 1'b1;
    step;
    load_start = 1'b0;
  endtask

  // Streams the map; invalid cycles carry inverted data as a trap.
  task automatic stream(input int kind, input bit toggle,
                        input int abort_at, input bit poke);
    int idx;
    int cyc;
    bit v;
    bit d;
    bit acc;
    idx = 0;
    cyc = 0;
    while (idx < CELLS && cyc < 3 * CELLS) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      d = (kind != 0) ? pat_b(idx) : pat_a(idx);
      load_valid = v;
      load_data = v ? d : ~d;
      load_start = poke && (cyc == 200);
      @(posedge clk);
      acc = v && (load_ready === 1'b1);
      #1;
      load_start = 1'b0;
      if (acc) begin
        mdl[idx] = d;
        idx++;
      end
      cyc++;
      if (abort_at > 0 && idx == abort_at) begin
        rst_n = 1'b0;
        break;
      end
    end
    load_valid = 1'b0;
    load_data = 1'b0;
    if (abort_at == 0) expect_st("load_accepts", S_VAL, CELLS, idx);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    settle;
    expect_st("rst_ready", S_READY, 0);
    expect_st("rst_load_ready", S_LRDY, 0);
    expect_st("rst_maze_in", S_MIN, 1);
`ifdef PATH_DUMP_EN
    expect_st("rst_visit_count", S_VCNT, 0);
    expect_st("rst_dump_visited", S_DVIS, 0);
`endif
    settle;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step;

    // Full load with valid held high
    lr_base = lr_cnt;
    start_load;
    stream(0, 1'b0, 0, 1'b0);
    expect_st("ready_after_load", S_READY, 1);
    expect_st("load_ready_after", S_LRDY, 0);
    settle;
    step;
    step;
    expect_st("load_ready_cycles", S_LRCNT, CELLS);
    settle;

    // Reads against wall=(r==0||c==0)
    rd(5, 7, 0);
    rd(0, 9, 1);
    step;
    expect_st("hold_one", S_MIN, 1);
    settle;
    rd(5, 7, 0);
    step;
    expect_st("hold_zero", S_MIN, 0);
    settle;
    rd(63, 63, 0);
    rd(63, 0, 1);
    rd(0, 63, 1);

    // Marking and dump
    mark(3, 3);
    mark(3, 3);
    mark(3, 4);
`ifdef PATH_DUMP_EN
    expect_st("visit_count_2", S_VCNT, 2);
    settle;
    dmp(3, 3, 1);
    dmp(4, 4, 0);
    dmp(3, 4, 1);
`endif

    // Read and mark the same wall cell together
    row = 6'd0;
    col = 6'd0;
    maze_oe = 1'b1;
    maze_we = 1'b1;
    rd_q.push_back(1'b1);
    step;
    maze_oe = 1'b0;
    maze_we = 1'b0;
`ifdef PATH_DUMP_EN
    expect_st("visit_count_3", S_VCNT, 3);
    settle;
    dmp(0, 0, 1);
`endif
    rd(0, 0, 1);
    mark(5, 7);
    rd(5, 7, 0);

    // Reload from READY clears the visited plane
    start_load;
    expect_st("reload_ready", S_READY, 0);
    expect_st("reload_load_ready", S_LRDY, 1);
`ifdef PATH_DUMP_EN
    expect_st("reload_visit_count", S_VCNT, 0);
`endif
    settle;
`ifdef PATH_DUMP_EN
    dmp(3, 3, 0);
    dmp(0, 0, 0);
`endif
    mark(5, 5);
`ifdef PATH_DUMP_EN
    dmp(5, 5, 0);
    expect_st("we_in_load_ignored", S_VCNT, 0);
    settle;
`endif
    rd(10, 10, 1);

    // Toggled valid, stray load_start mid-load, full readback
    stream(1, 1'b1, 0, 1'b1);
    expect_st("ready_after_toggle", S_READY, 1);
    settle;
    for (int i = 0; i < CELLS; i++) rd(i >> 6, i & 63, mdl[i]);

    // Reset in the middle of a load
    start_load;
    stream(0, 1'b0, 2000, 1'b0);
    expect_st("abort_ready", S_READY, 0);
    expect_st("abort_load_ready", S_LRDY, 0);
    expect_st("abort_maze_in", S_MIN, 1);
`ifdef PATH_DUMP_EN
    expect_st("abort_visit_count", S_VCNT, 0);
`endif
    settle;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step;
    rd(1, 1, 1);
    rd(5, 7, 1);
    start_load;
    stream(0, 1'b0, 0, 1'b0);
    expect_st("ready_after_abort", S_READY, 1);
    settle;
    rd(5, 7, 0);
    rd(0, 9, 1);
    rd(63, 63, 0);

    step;
    step;
    expect_st("scoreboard_drain", S_DRAIN, 0);
    settle;
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
